// File: rtl/adc_lcd_display.sv
// adc_lcd_display
// Takes a 16-bit ADC result, clamps it to 0..9999, converts it to four BCD
// digits with an iterative double-dabble (one shift per cycle) and writes it
// to an HD44780-compatible character LCD over an 8-bit parallel bus.
// After reset the block waits POWERUP_CYC cycles and sends the init sequence
// 0x38, 0x0C, 0x06, 0x01. Each display update then sends LINE_ADDR followed by
// four ASCII digits.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   sample_in    unsigned ADC result, qualified by sample_valid
//   sample_valid one-cycle strobe
//   busy         high in every state except IDLE
//   update_done  one-cycle pulse when the last digit's post-byte wait ends
//   lcd_rs       register select (0 = command, 1 = data)
//   lcd_en       enable strobe (registered, glitch-free)
//   lcd_data     LCD data bus
//   state_dbg    current FSM state, for observation only
//
// Input handshake: sample_valid has no ready. A strobe is accepted in any
// state and lands in a one-deep pending register; a newer sample overwrites
// an older one that has not been consumed. IDLE consumes the pending sample.
module adc_lcd_display #(
    parameter int         POWERUP_CYC  = 750000,
    parameter int         SETUP_CYC    = 2,
    parameter int         EN_HIGH_CYC  = 12,
    parameter int         CMD_WAIT_CYC = 2000,
    parameter int         CLR_WAIT_CYC = 82000,
    parameter logic [7:0] LINE_ADDR    = 8'h80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic        busy,
    output logic        update_done,
    output logic        lcd_rs,
    output logic        lcd_en,
    output logic [7:0]  lcd_data,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_PWRUP   = 3'd0,
        S_INIT    = 3'd1,
        S_IDLE    = 3'd2,
        S_CONVERT = 3'd3,
        S_WRITE   = 3'd4
    } state_t;

    localparam logic [31:0] PWR_LAST  = 32'(POWERUP_CYC - 1);
    localparam logic [31:0] SETUP     = 32'(SETUP_CYC);
    localparam logic [31:0] EN_END    = 32'(SETUP_CYC + EN_HIGH_CYC);
    localparam logic [31:0] CMD_LAST  = 32'(SETUP_CYC + EN_HIGH_CYC + CMD_WAIT_CYC - 1);
    localparam logic [31:0] CLR_LAST  = 32'(SETUP_CYC + EN_HIGH_CYC + CLR_WAIT_CYC - 1);
    localparam logic [31:0] DD_LAST   = 32'd13;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic        rs_q, rs_d;
    logic        en_q, en_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        pend_flag_q, pend_flag_d;
    logic [15:0] pend_val_q, pend_val_d;
    logic [13:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d;

    logic        byte_last;
    logic [15:0] bcd_adj;

    function automatic logic [7:0] init_byte(input logic [2:0] i);
        case (i)
            3'd0:    init_byte = 8'h38;
            3'd1:    init_byte = 8'h0C;
            3'd2:    init_byte = 8'h06;
            default: init_byte = 8'h01;
        endcase
    endfunction

    // Data byte i (1..4) of an update is the ASCII of thousands..units.
    function automatic logic [7:0] digit_char(input logic [2:0] i, input logic [15:0] bcd);
        case (i)
            3'd1:    digit_char = {4'h3, bcd[15:12]};
            3'd2:    digit_char = {4'h3, bcd[11:8]};
            3'd3:    digit_char = {4'h3, bcd[7:4]};
            default: digit_char = {4'h3, bcd[3:0]};
        endcase
    endfunction

    // The byte currently on the bus decides the length of its own post-byte wait.
    assign byte_last = (data_q == 8'h01) ? (cnt_q == CLR_LAST) : (cnt_q == CMD_LAST);

    // Double-dabble correction: +3 on every BCD nibble >= 5 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int n = 0; n < 4; n++) begin
            if (bcd_q[n*4 +: 4] >= 4'd5) begin
                bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        rs_d        = rs_q;
        data_d      = data_q;
        done_d      = 1'b0;
        pend_flag_d = pend_flag_q;
        pend_val_d  = pend_val_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;

        case (state_q)
            S_PWRUP: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    rs_d    = 1'b0;
                    data_d  = init_byte(3'd0);
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_INIT: begin
                if (byte_last) begin
                    cnt_d = '0;
                    if (idx_q == 3'd3) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        rs_d   = 1'b0;
                        data_d = init_byte(idx_q + 3'd1);
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_IDLE: begin
                if (pend_flag_q) begin
                    pend_flag_d = 1'b0;
                    bin_d       = (pend_val_q > 16'd9999) ? 14'd9999 : pend_val_q[13:0];
                    bcd_d       = '0;
                    cnt_d       = '0;
                    state_d     = S_CONVERT;
                end
            end
            S_CONVERT: begin
                bcd_d = {bcd_adj[14:0], bin_q[13]};
                bin_d = {bin_q[12:0], 1'b0};
                if (cnt_q == DD_LAST) begin
                    state_d = S_WRITE;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    rs_d    = 1'b0;
                    data_d  = LINE_ADDR;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_WRITE: begin
                if (byte_last) begin
                    cnt_d = '0;
                    if (idx_q == 3'd4) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        rs_d   = 1'b1;
                        data_d = digit_char(idx_q + 3'd1, bcd_q);
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = S_PWRUP;
        endcase

        // A strobe always wins over the IDLE consume, so a sample arriving in
        // the consume cycle stays pending for the next update.
        if (sample_valid) begin
            pend_flag_d = 1'b1;
            pend_val_d  = sample_in;
        end

        // lcd_en is a registered decode of the next byte-cycle count.
        en_d = ((state_d == S_INIT) || (state_d == S_WRITE)) &&
               (cnt_d >= SETUP) && (cnt_d < EN_END);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_PWRUP;
            cnt_q       <= '0;
            idx_q       <= '0;
            rs_q        <= 1'b0;
            en_q        <= 1'b0;
            data_q      <= 8'h00;
            done_q      <= 1'b0;
            pend_flag_q <= 1'b0;
            pend_val_q  <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rs_q        <= rs_d;
            en_q        <= en_d;
            data_q      <= data_d;
            done_q      <= done_d;
            pend_flag_q <= pend_flag_d;
            pend_val_q  <= pend_val_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign update_done = done_q;
    assign lcd_rs      = rs_q;
    assign lcd_en      = en_q;
    assign lcd_data    = data_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_adc_lcd_display.sv
module tb_adc_lcd_display;

  localparam int PWR   = 20;
  localparam int SETUP = 2;
  localparam int ENH   = 4;
  localparam int CMDW  = 5;
  localparam int CLRW  = 10;
  localparam logic [7:0] LINE = 8'h80;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic [15:0] sample_in;
  logic sample_valid;
  logic busy, update_done, lcd_rs, lcd_en;
  logic [7:0] lcd_data;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  adc_lcd_display #(
    .POWERUP_CYC(PWR), .SETUP_CYC(SETUP), .EN_HIGH_CYC(ENH),
    .CMD_WAIT_CYC(CMDW), .CLR_WAIT_CYC(CLRW), .LINE_ADDR(LINE)
  ) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .busy(busy), .update_done(update_done), .lcd_rs(lcd_rs), .lcd_en(lcd_en),
    .lcd_data(lcd_data), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[$];   // {rs, data} of each expected byte, in bus order
  int total = 0;
  int bad = 0;
  int exp_done = 0;
  int done_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h) t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
  endtask

  task automatic push_update(input int v, input bit expect_done);
    int c;
    c = (v > 9999) ? 9999 : v;
    exp_q.push_back({1'b0, LINE});
    exp_q.push_back({1'b1, 8'(8'h30 + (c / 1000) % 10)});
    exp_q.push_back({1'b1, 8'(8'h30 + (c / 100) % 10)});
    exp_q.push_back({1'b1, 8'(8'h30 + (c / 10) % 10)});
    exp_q.push_back({1'b1, 8'(8'h30 + c % 10)});
    if (expect_done) exp_done++;
  endtask

  function automatic logic [15:0] rand_sample();
    case ($urandom_range(0, 5))
      0: rand_sample = 16'($urandom_range(0, 9));
      1: rand_sample = 16'($urandom_range(9990, 10010));
      2: rand_sample = 16'($urandom_range(0, 65535));
      3: rand_sample = 16'($urandom_range(0, 9999));
      4: rand_sample = 16'hFFFF;
      default: rand_sample = 16'd9999;
    endcase
  endfunction

  // ---------------- driver tasks (called just after a negedge) ----------------
  task automatic drive_sample(input logic [15:0] v);
    sample_in = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_busy();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) begin ok = 1; break; end
    end
    check("wait_busy_timeout", int'(ok), 1);
  endtask

  // Quiet = busy low for 20 consecutive cycles.
  task automatic wait_quiet();
    int q = 0;
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) q++; else q = 0;
      if (q >= 20) begin ok = 1; break; end
    end
    check("wait_quiet_timeout", int'(ok), 1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [8:0] got, e, cur_byte;
    int since_rise, high_cnt, group_bytes;
    logic en_prev;
    bit have_prev;
    en_prev = 0; since_rise = 0; high_cnt = 0; group_bytes = 0; have_prev = 0; cur_byte = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        en_prev = 0; since_rise = 0; high_cnt = 0; group_bytes = 0; have_prev = 0;
      end else begin
        since_rise++;
        got = {lcd_rs, lcd_data};
        if (lcd_en && !en_prev) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_byte: got=0x%0h expected=none t=%0t", got, $time);
          end else begin
            e = exp_q.pop_front();
            check("lcd_byte", int'(got), int'(e));
            if (e != {1'b0, LINE} && e != 9'h038) begin
              if (have_prev)
                check("byte_spacing", since_rise,
                      ENH + SETUP + ((cur_byte[7:0] == 8'h01) ? CLRW : CMDW));
              group_bytes++;
            end else begin
              group_bytes = 1;
            end
          end
          cur_byte = got; have_prev = 1; since_rise = 0; high_cnt = 1;
        end else if (lcd_en) begin
          high_cnt++;
          check("bus_stable_en_high", int'(got), int'(cur_byte));
        end
        if (!lcd_en && en_prev) check("en_width", high_cnt, ENH);
        if (update_done) begin
          done_seen++;
          check("done_after_4th_digit", group_bytes, 5);
          check("done_latency", since_rise, ENH + CMDW);
          group_bytes = 0;
        end
        en_prev = lcd_en;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    bit ok;
    logic [15:0] v, last;
    rst = 1'b1;
    sample_valid = 1'b0;
    sample_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 1);
    check("rst_en", int'(lcd_en), 0);
    check("rst_rs", int'(lcd_rs), 0);
    check("rst_data", int'(lcd_data), 0);
    check("rst_done", int'(update_done), 0);

    // Power-up + init timing.
    rst = 1'b0;
    push_init();
    k = 0; ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); k++;
      if (lcd_en) begin ok = 1; break; end
    end
    check("pwrup_found_en", int'(ok), 1);
    check("pwrup_to_first_en", k, PWR + SETUP);
    k = 0; ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); k++;
      if (!busy) begin ok = 1; break; end
    end
    check("init_found_idle", int'(ok), 1);
    check("first_en_to_idle", k, (ENH + CMDW) + 2 * (SETUP + ENH + CMDW) + (SETUP + ENH + CLRW));

    // Directed values.
    drive_sample(16'd1234);  push_update(1234, 1);  wait_quiet();
    drive_sample(16'd0);     push_update(0, 1);     wait_quiet();
    drive_sample(16'd12000); push_update(12000, 1); wait_quiet();
    drive_sample(16'hFFFF);  push_update(65535, 1); wait_quiet();
    drive_sample(16'd9999);  push_update(9999, 1);  wait_quiet();
    drive_sample(16'd10000); push_update(10000, 1); wait_quiet();

    // Samples while busy: only the newest one is shown afterwards.
    drive_sample(16'd1234); push_update(1234, 1);
    wait_busy();
    drive_sample(16'd555);
    repeat (7) @(negedge clk);
    drive_sample(16'd42);   push_update(42, 1);
    wait_quiet();

    // Randomized updates, some with a burst while busy.
    for (int n = 0; n < 20; n++) begin
      v = rand_sample();
      drive_sample(v); push_update(int'(v), 1);
      if ($urandom_range(0, 1) == 1) begin
        wait_busy();
        last = v;
        for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
          repeat ($urandom_range(0, 10)) @(negedge clk);
          last = rand_sample();
          drive_sample(last);
        end
        push_update(int'(last), 1);
      end
      wait_quiet();
    end

    // Reset during the 3rd digit's en-high window, with a sample pending.
    drive_sample(16'd1234); push_update(1234, 0);
    wait_busy();
    drive_sample(16'd777);
    k = 0; ok = 0;
    begin
      logic p;
      p = lcd_en;
      for (int i = 0; i < 500; i++) begin
        @(negedge clk);
        if (lcd_en && !p) k++;
        p = lcd_en;
        if (k == 4) begin ok = 1; break; end
      end
    end
    check("found_3rd_digit", int'(ok), 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_en", int'(lcd_en), 0);
    check("midrst_data", int'(lcd_data), 0);
    check("midrst_rs", int'(lcd_rs), 0);
    check("midrst_busy", int'(busy), 1);
    check("midrst_done", int'(update_done), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_init();
    wait_quiet();
    repeat (40) @(negedge clk);
    check("pending_discarded_queue", exp_q.size(), 0);

    // Sample during PWRUP is shown right after init.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_init();
    repeat (5) @(negedge clk);
    drive_sample(16'd4321); push_update(4321, 1);
    wait_quiet();

    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("update_done_count", done_seen, exp_done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time guard.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
